// File: rtl/arith_state_machine.sv
// Valid/ready arithmetic sequencer: single-cycle ADD/SUB and iterative
// shift-add unsigned MUL, with the result held until the sink accepts it.
module arith_state_machine #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_res,
  output logic               out_carry,
  output logic               out_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_RSV} op_t;

  state_t             state, state_n;
  op_t                op_in;
  logic [2*WIDTH-1:0] acc, mcand, acc_step;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               mul_last;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;

  assign op_in     = op_t'(op);
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Multiplier shifts right and multiplicand shifts left, so each MUL cycle
  // only ever examines bit 0 and adds the pre-shifted multiplicand.
  always_comb begin
    acc_step = mplier[0] ? (acc + mcand) : acc;
    mul_last = (cnt == CW'(WIDTH - 1));
    sum      = {1'b0, a} + {1'b0, b};
    diff     = a - b;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (in_valid) state_n = (op_in == OP_MUL) ? S_MUL : S_DONE;
      S_MUL:  if (mul_last) state_n = S_DONE;
      S_DONE: if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_res   <= '0;
      out_carry <= 1'b0;
      out_err   <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            case (op_in)
              OP_ADD: begin
                out_res   <= {{(WIDTH-1){1'b0}}, sum};
                out_carry <= sum[WIDTH];
                out_err   <= 1'b0;
              end
              OP_SUB: begin
                out_res   <= {{WIDTH{1'b0}}, diff};
                out_carry <= (a < b);
                out_err   <= 1'b0;
              end
              OP_MUL: begin
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                acc    <= '0;
                cnt    <= '0;
              end
              default: begin
                out_res   <= '0;
                out_carry <= 1'b0;
                out_err   <= 1'b1;
              end
            endcase
          end
        end
        S_MUL: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (mul_last) begin
            out_res   <= acc_step;
            out_carry <= |acc_step[2*WIDTH-1:WIDTH];
            out_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
